peak_search_sequencer: RTL and testbench

- Sequences one spectrum peak search per request.
- Sweeps magnitude RAM addresses 0..N_BINS-1 and drives the serial peak finder's start/enable/data with correct read-latency alignment.
- Captures the finder's peak index and reports it with a done pulse.
- Sits between the FFT magnitude buffer and the pitch-estimation logic.

---
 rtl/peak_seq_pkg.sv | 16 +
 rtl/rd_valid_delay.sv | 69 ++++++
 rtl/peak_search_sequencer.sv | 171 +++++++++++++++++
 tb/tb_peak_search_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_seq_pkg.sv
// Shared definitions for the spectrum peak-search sequencer.
// Holds the sequencer state encoding and the default address/data widths,
// which are shared with the serial peak finder.
package peak_seq_pkg;

    localparam int unsigned DefAddrW = 12;
    localparam int unsigned DefDataW = 18;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StDrain   = 2'd2,
        StCapture = 2'd3
    } seq_state_e;

endpackage

// File: rtl/rd_valid_delay.sv
// Read-valid delay line: a Depth-stage shift register that re-times the RAM
// read strobe and the first-read flag so they line up with the read data.
// With PEAK_SEQ_DC_MASK_EN defined it also carries the bin index of each read.
//
// Ports:
//   clk_i    system clock
//   rst_ni   synchronous active-low clear of every stage
//   valid_i  read strobe entering the line
//   first_i  first-read flag entering the line
//   idx_i    bin index entering the line (PEAK_SEQ_DC_MASK_EN only)
//   idx_o    bin index leaving the line (PEAK_SEQ_DC_MASK_EN only)
//   valid_o  read strobe delayed by Depth cycles
//   first_o  first-read flag delayed by Depth cycles
//   any_o    some stage still holds a read in flight
module rd_valid_delay #(
    parameter int unsigned Depth = 2
`ifdef PEAK_SEQ_DC_MASK_EN
    , parameter int unsigned IdxW = 12
`endif
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic            first_i,
`ifdef PEAK_SEQ_DC_MASK_EN
    input  logic [IdxW-1:0] idx_i,
    output logic [IdxW-1:0] idx_o,
`endif
    output logic            valid_o,
    output logic            first_o,
    output logic            any_o
);

    logic [Depth-1:0] valid_q;
    logic [Depth-1:0] first_q;

    // Stage 0 is the newest entry; the cast drops the oldest bit and also
    // covers the single-stage case.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
            first_q <= '0;
        end else begin
            valid_q <= Depth'({valid_q, valid_i});
            first_q <= Depth'({first_q, first_i});
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign first_o = first_q[Depth-1];
    assign any_o   = |valid_q;

`ifdef PEAK_SEQ_DC_MASK_EN
    localparam int unsigned IdxBits = Depth * IdxW;

    logic [Depth-1:0][IdxW-1:0] idx_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else begin
            idx_q <= IdxBits'({idx_q, idx_i});
        end
    end

    assign idx_o = idx_q[Depth-1];
`endif

endmodule

// File: rtl/peak_search_sequencer.sv
// Peak-search sequencer: on each request sweeps magnitude RAM addresses
// 0..NBins-1, feeds the serial peak finder with start/enable/data aligned to
// the RAM read latency, then captures the finder's peak index and pulses done.
// Optional build macro PEAK_SEQ_DC_MASK_EN zeroes the data of bins below DcSkip
// so the DC/low-frequency bins can never win.
//
// Ports:
//   clk_i            system clock
//   rst_ni           synchronous active-low reset
//   req_i            one-cycle search request
//   ovr_clr_i        clears the sticky overrun flag
//   busy_o           search in progress
//   done_o           one-cycle pulse, peak_bin_o valid
//   peak_bin_o       captured peak index, held until the next done
//   overrun_o        sticky, set when req_i arrives outside IDLE
//   mem_addr_o       magnitude RAM read address
//   mem_rd_o         magnitude RAM read enable
//   mem_data_i       RAM read data, ReadLat cycles after the address
//   pf_start_o       finder start pulse, coincident with bin 0's data
//   pf_enable_o      finder enable, high for NBins consecutive cycles
//   pf_data_o        finder data
//   pf_peak_index_i  finder result
module peak_search_sequencer
    import peak_seq_pkg::*;
#(
    parameter int unsigned NBins   = 2048,
    parameter int unsigned AddrW   = DefAddrW,
    parameter int unsigned DataW   = DefDataW,
    parameter int unsigned ReadLat = 2,
    parameter int unsigned DcSkip  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic             ovr_clr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [AddrW-1:0] peak_bin_o,
    output logic             overrun_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic             mem_rd_o,
    input  logic [DataW-1:0] mem_data_i,
    output logic             pf_start_o,
    output logic             pf_enable_o,
    output logic [DataW-1:0] pf_data_o,
    input  logic [AddrW-1:0] pf_peak_index_i
);

    localparam logic [AddrW-1:0] LastAddr = AddrW'(NBins - 1);

    seq_state_e       state_q, state_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [AddrW-1:0] peak_q, peak_d;
    logic             overrun_q, overrun_d;

    logic dly_valid;
    logic dly_first;
    logic dly_any;
    logic first_rd;

    assign mem_rd_o = (state_q == StIssue);
    assign first_rd = mem_rd_o && (addr_q == '0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        peak_d  = peak_q;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    state_d = StIssue;
                    addr_d  = '0;
                end
            end
            StIssue: begin
                // Address saturates at the last bin; it never wraps.
                if (addr_q == LastAddr) begin
                    state_d = StDrain;
                end else begin
                    addr_d = addr_q + AddrW'(1);
                end
            end
            StDrain: begin
                // Empty delay line means the last datum was presented one
                // cycle ago, so the finder's registered result is now stable.
                if (!dly_any) begin
                    state_d = StCapture;
                    peak_d  = pf_peak_index_i;
                end
            end
            StCapture: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Set beats clear: a rejected request in the same cycle as ovr_clr_i wins.
    always_comb begin
        overrun_d = overrun_q;
        if (req_i && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end else if (ovr_clr_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            peak_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            peak_q    <= peak_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy_o      = (state_q == StIssue) || (state_q == StDrain);
    assign done_o      = (state_q == StCapture);
    assign peak_bin_o  = peak_q;
    assign overrun_o   = overrun_q;
    assign mem_addr_o  = addr_q;
    assign pf_enable_o = dly_valid;
    assign pf_start_o  = dly_first;

`ifdef PEAK_SEQ_DC_MASK_EN
    logic [AddrW-1:0] dly_idx;

    rd_valid_delay #(
        .Depth (ReadLat),
        .IdxW  (AddrW)
    ) u_rd_valid_delay (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (mem_rd_o),
        .first_i (first_rd),
        .idx_i   (addr_q),
        .idx_o   (dly_idx),
        .valid_o (dly_valid),
        .first_o (dly_first),
        .any_o   (dly_any)
    );

    assign pf_data_o = (dly_valid && (32'(dly_idx) >= DcSkip)) ? mem_data_i : '0;
`else
    rd_valid_delay #(
        .Depth (ReadLat)
    ) u_rd_valid_delay (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (mem_rd_o),
        .first_i (first_rd),
        .valid_o (dly_valid),
        .first_o (dly_first),
        .any_o   (dly_any)
    );

    // Gated so the finder sees a quiet bus outside the sweep.
    assign pf_data_o = dly_valid ? mem_data_i : '0;

    logic unused_dc_skip;
    assign unused_dc_skip = (DcSkip != 0);
`endif

endmodule

// File: tb/tb_peak_search_sequencer.sv
// Scoreboard bench: three sequencers (read latency 2, 1 and 4) share one
// request stream. Each has its own RAM and serial-finder model. Expected
// results come from a first-maximum search over the RAM contents.
module tb_peak_search_sequencer;

    localparam int unsigned N   = 8;
    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 18;
    localparam int unsigned DCS = 4;
    localparam int LATS [3] = '{2, 1, 4};
`ifdef PEAK_SEQ_DC_MASK_EN
    localparam bit Mask = 1'b1;
`else
    localparam bit Mask = 1'b0;
`endif

    typedef struct {
        int done_cyc;
        int start_cyc;
        int peak;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          ovr_clr;
    logic          busy      [3];
    logic          done      [3];
    logic          overrun   [3];
    logic          mem_rd    [3];
    logic          pf_start  [3];
    logic          pf_enable [3];
    logic [AW-1:0] peak_bin  [3];
    logic [AW-1:0] mem_addr  [3];
    logic [AW-1:0] fidx      [3];
    logic [DW-1:0] mem_data  [3];
    logic [DW-1:0] pf_data   [3];

    logic [DW-1:0] ram [N];
    logic [AW-1:0] apipe [3][4];
    logic [DW-1:0] fmax [3];
    int            fcnt [3];

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    bit   mon_on = 1'b0;
    exp_t sbq [3][$];
    int   free_at [3];
    int   b_lo [3];
    int   b_hi [3];
    bit   ovr_exp [3];
    int   last_start [3];
    int   hold [3];
    int   en_run [3];

    peak_search_sequencer #(
        .NBins(N), .AddrW(AW), .DataW(DW), .ReadLat(2), .DcSkip(DCS)
    ) u_dut_l2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ovr_clr_i(ovr_clr),
        .busy_o(busy[0]), .done_o(done[0]), .peak_bin_o(peak_bin[0]),
        .overrun_o(overrun[0]), .mem_addr_o(mem_addr[0]), .mem_rd_o(mem_rd[0]),
        .mem_data_i(mem_data[0]), .pf_start_o(pf_start[0]), .pf_enable_o(pf_enable[0]),
        .pf_data_o(pf_data[0]), .pf_peak_index_i(fidx[0])
    );

    peak_search_sequencer #(
        .NBins(N), .AddrW(AW), .DataW(DW), .ReadLat(1), .DcSkip(DCS)
    ) u_dut_l1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ovr_clr_i(ovr_clr),
        .busy_o(busy[1]), .done_o(done[1]), .peak_bin_o(peak_bin[1]),
        .overrun_o(overrun[1]), .mem_addr_o(mem_addr[1]), .mem_rd_o(mem_rd[1]),
        .mem_data_i(mem_data[1]), .pf_start_o(pf_start[1]), .pf_enable_o(pf_enable[1]),
        .pf_data_o(pf_data[1]), .pf_peak_index_i(fidx[1])
    );

    peak_search_sequencer #(
        .NBins(N), .AddrW(AW), .DataW(DW), .ReadLat(4), .DcSkip(DCS)
    ) u_dut_l4 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ovr_clr_i(ovr_clr),
        .busy_o(busy[2]), .done_o(done[2]), .peak_bin_o(peak_bin[2]),
        .overrun_o(overrun[2]), .mem_addr_o(mem_addr[2]), .mem_rd_o(mem_rd[2]),
        .mem_data_i(mem_data[2]), .pf_start_o(pf_start[2]), .pf_enable_o(pf_enable[2]),
        .pf_data_o(pf_data[2]), .pf_peak_index_i(fidx[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM with per-instance read latency: data for the address seen in
    // cycle c appears in cycle c+LATS[k].
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            apipe[k][0] <= mem_addr[k];
            for (int s = 1; s < 4; s++) apipe[k][s] <= apipe[k][s-1];
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) mem_data[k] = ram[apipe[k][LATS[k]-1][2:0]];
    end

    // Serial finder: registered first-maximum tracker.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (pf_start[k]) begin
                fmax[k] <= pf_data[k];
                fidx[k] <= '0;
                fcnt[k] <= 1;
            end else if (pf_enable[k]) begin
                if (pf_data[k] > fmax[k]) begin
                    fmax[k] <= pf_data[k];
                    fidx[k] <= AW'(fcnt[k]);
                end
                fcnt[k] <= fcnt[k] + 1;
            end
        end
    end

    function automatic int mval(input int b);
        if (b < 0 || b > int'(N) - 1) return -1;
        if (Mask && b < int'(DCS)) return 0;
        return int'(ram[b]);
    endfunction

    function automatic int exp_peak();
        int best;
        best = 0;
        for (int b = 1; b < int'(N); b++) if (mval(b) > mval(best)) best = b;
        return best;
    endfunction

    task automatic chk(input bit ok, input string name, input int k, input int act,
                       input int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s dut%0d (lat %0d) cycle %0d: got %0d, want %0d",
                     name, k, LATS[k], cyc, act, expv);
        end
    endtask

    task automatic chk_eq(input string name, input int k, input int act, input int expv);
        chk(act == expv, name, k, act, expv);
    endtask

    // One cycle of stimulus; the model decides acceptance from its own
    // record of when each instance is free again.
    task automatic drive(input bit rq, input bit clr);
        int   r;
        exp_t e;
        r = cyc;
        req = rq;
        ovr_clr = clr;
        for (int k = 0; k < 3; k++) begin
            if (rq && r < free_at[k]) ovr_exp[k] = 1'b1;
            else if (clr) ovr_exp[k] = 1'b0;
            if (rq && r >= free_at[k]) begin
                e.done_cyc  = r + int'(N) + LATS[k] + 2;
                e.start_cyc = r + 1 + LATS[k];
                e.peak      = exp_peak();
                sbq[k].push_back(e);
                b_lo[k]    = r + 1;
                b_hi[k]    = e.done_cyc - 1;
                free_at[k] = e.done_cyc + 1;
            end
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        ovr_clr = 1'b0;
        for (int k = 0; k < 3; k++) chk_eq("overrun", k, int'(overrun[k]), int'(ovr_exp[k]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sbq[k].delete();
            if (b_hi[k] > cyc) b_hi[k] = cyc;
            free_at[k] = cyc + 1;
            ovr_exp[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int lim;
        lim = 0;
        while ((cyc < free_at[0] || cyc < free_at[1] || cyc < free_at[2]) && lim < 200) begin
            drive(1'b0, 1'b0);
            lim++;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        int   tap;
        if (mon_on) begin
            for (int k = 0; k < 3; k++) begin
                tap = int'(apipe[k][LATS[k]-1]);
                chk_eq("busy", k, int'(busy[k]), int'(cyc >= b_lo[k] && cyc <= b_hi[k]));
                chk(mem_addr[k] <= AW'(N - 1), "mem_addr_bound", k, int'(mem_addr[k]), N - 1);
                if (pf_enable[k]) chk_eq("pf_data", k, int'(pf_data[k]), mval(tap));
                if (pf_start[k]) begin
                    chk(pf_enable[k] && tap == 0, "start_align", k, tap, 0);
                    last_start[k] = cyc;
                end
                if (!rst_n) en_run[k] = 0;
                else if (pf_enable[k]) en_run[k]++;
                else if (en_run[k] != 0) begin
                    chk_eq("enable_len", k, en_run[k], N);
                    en_run[k] = 0;
                end
                if (done[k]) begin
                    if (sbq[k].size() == 0) begin
                        chk_eq("unexpected_done", k, int'(done[k]), 0);
                    end else begin
                        e = sbq[k].pop_front();
                        chk_eq("done_cycle", k, cyc, e.done_cyc);
                        chk_eq("start_cycle", k, last_start[k], e.start_cyc);
                        chk_eq("busy_in_done", k, int'(busy[k]), 0);
                        hold[k] = e.peak;
                    end
                end else if (sbq[k].size() > 0 && sbq[k][0].done_cyc < cyc) begin
                    chk_eq("missed_done", k, int'(done[k]), 1);
                    void'(sbq[k].pop_front());
                end
                chk_eq("peak_bin", k, int'(peak_bin[k]), hold[k]);
                if (!rst_n) hold[k] = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        int gap;
        int span;
        rst_n = 1'b0;
        req = 1'b0;
        ovr_clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            free_at[k] = 0;
            b_lo[k] = 1;
            b_hi[k] = 0;
            ovr_exp[k] = 1'b0;
            last_start[k] = -1;
            hold[k] = 0;
            en_run[k] = 0;
        end
        for (int b = 0; b < int'(N); b++) ram[b] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk_eq("rst_busy", k, int'(busy[k]), 0);
            chk_eq("rst_done", k, int'(done[k]), 0);
            chk_eq("rst_mem_rd", k, int'(mem_rd[k]), 0);
            chk_eq("rst_pf_start", k, int'(pf_start[k]), 0);
            chk_eq("rst_pf_enable", k, int'(pf_enable[k]), 0);
            chk_eq("rst_overrun", k, int'(overrun[k]), 0);
            chk_eq("rst_mem_addr", k, int'(mem_addr[k]), 0);
            chk_eq("rst_peak_bin", k, int'(peak_bin[k]), 0);
            chk_eq("rst_pf_data", k, int'(pf_data[k]), 0);
        end
        rst_n = 1'b1;
        mon_on = 1'b1;

        // Directed sweep, overrun set/clear priority, request in done cycle.
        ram = '{5, 9, 3, 20, 7, 20, 1, 2};
        while (cyc < 10) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        while (cyc < 22) drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        wait_idle();
        drive(1'b0, 1'b1);

        // Reset in the middle of a search.
        drive(1'b1, 1'b0);
        repeat (4) drive(1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            chk_eq("abort_busy", k, int'(busy[k]), 0);
            chk_eq("abort_peak_bin", k, int'(peak_bin[k]), 0);
            chk_eq("abort_done", k, int'(done[k]), 0);
        end
        drive(1'b1, 1'b0);
        wait_idle();

        // Large low bins: masked away when the DC mask is compiled in.
        ram = '{50, 40, 1, 1, 9, 2, 3, 1};
        drive(1'b1, 1'b0);
        wait_idle();

        // Random contents (some rounds with many ties) and random request gaps.
        for (int rd = 0; rd < 16; rd++) begin
            wait_idle();
            span = (rd % 3 == 0) ? 3 : 31;
            for (int b = 0; b < int'(N); b++) ram[b] = DW'($urandom_range(0, span));
            nreq = $urandom_range(1, 3);
            for (int q = 0; q < nreq; q++) begin
                gap = $urandom_range(0, 14);
                repeat (gap) drive(1'b0, $urandom_range(0, 3) == 0);
                drive(1'b1, $urandom_range(0, 3) == 0);
            end
        end
        wait_idle();
        repeat (3) drive(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) chk_eq("sb_drain", k, sbq[k].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
